// File: rtl/dlfloat_pkg.sv
// Shared DLFloat16 constants and the operand-sequencer state encoding.
// Format: 1 sign bit, 6 exponent bits (bias 31), 9 mantissa bits.
package dlfloat_pkg;

  localparam logic [15:0] DLF_NAN  = 16'hFFFF;
  localparam logic [15:0] DLF_ZERO = 16'h0000;
  localparam logic [15:0] DLF_ONE  = 16'h3E00;
  localparam int          DLF_EXP_BIAS = 31;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_FEED  = 3'd1,
    ST_WAIT  = 3'd2,
    ST_DRAIN = 3'd3,
    ST_HOLD  = 3'd4
  } seq_state_e;

  function automatic logic is_nan(input logic [15:0] x);
    return x == DLF_NAN;
  endfunction

endpackage

// File: rtl/dlfloat_mac_seq.sv
// Operand sequencer for the DLFloat16 MAC: paces operand issue to the MAC
// feedback loop, clears the accumulator between vectors and returns the result.
module dlfloat_mac_seq
  import dlfloat_pkg::*;
#(
  parameter int MAC_LAT   = 4,
  parameter int ISSUE_GAP = 2,
  parameter int CNT_W     = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [15:0]      in_a,
  input  logic [15:0]      in_b,
  input  logic             in_last,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [15:0]      mac_a,
  output logic [15:0]      mac_b,
  output logic             mac_clr,
  input  logic [15:0]      mac_c,
  output logic [15:0]      res_data,
  output logic [CNT_W-1:0] res_count,
  output logic             res_nan,
  output logic             res_valid,
  input  logic             res_ready
);

  localparam logic [3:0]       DRAIN_INIT = 4'(MAC_LAT);
  localparam logic [3:0]       GAP_INIT   = 4'(ISSUE_GAP - 1);
  localparam logic [CNT_W-1:0] CNT_MAX    = '1;

  seq_state_e       state;
  seq_state_e       accept_state;
  logic [3:0]       gap_cnt;
  logic [3:0]       drain_cnt;
  logic [CNT_W-1:0] elem_cnt;
  logic             nan_flag;
  logic             accept;
  logic             in_nan;

  // NOTE: in_ready is masked by rst so no pair can be accepted while reset is held.
  assign in_ready = ~rst & ((state == ST_IDLE) || (state == ST_FEED));
  assign accept   = in_valid & in_ready;
  assign in_nan   = is_nan(in_a) | is_nan(in_b);

  always_comb begin
    accept_state = ST_FEED;
    if (in_last)            accept_state = ST_DRAIN;
    else if (ISSUE_GAP > 1) accept_state = ST_WAIT;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= ST_IDLE;
      mac_a     <= DLF_ZERO;
      mac_b     <= DLF_ZERO;
      mac_clr   <= 1'b1;
      gap_cnt   <= '0;
      drain_cnt <= '0;
      elem_cnt  <= '0;
      nan_flag  <= 1'b0;
      res_data  <= DLF_ZERO;
      res_count <= '0;
      res_nan   <= 1'b0;
      res_valid <= 1'b0;
    end else begin
      // NOTE: non-blocking throughout; these defaults issue a zero product
      // (additive identity) unless a later assignment in this block wins.
      mac_a <= DLF_ZERO;
      mac_b <= DLF_ZERO;
      if (accept) begin
        mac_a     <= in_a;
        mac_b     <= in_b;
        mac_clr   <= 1'b0;
        gap_cnt   <= GAP_INIT;
        drain_cnt <= DRAIN_INIT;
        state     <= accept_state;
      end
      case (state)
        ST_IDLE: begin
          if (accept) begin
            elem_cnt <= CNT_W'(1);
            nan_flag <= in_nan;
          end else begin
            mac_clr  <= 1'b1;
            elem_cnt <= '0;
            nan_flag <= 1'b0;
          end
        end
        ST_FEED: begin
          if (accept) begin
            elem_cnt <= (elem_cnt == CNT_MAX) ? elem_cnt : elem_cnt + 1'b1;
            nan_flag <= nan_flag | in_nan;
          end
        end
        ST_WAIT: begin
          if (gap_cnt <= 4'd1) state <= ST_FEED;
          else                 gap_cnt <= gap_cnt - 1'b1;
        end
        ST_DRAIN: begin
          if (drain_cnt <= 4'd1) begin
            res_data  <= mac_c;
            res_count <= elem_cnt;
            res_nan   <= nan_flag | is_nan(mac_c);
            res_valid <= 1'b1;
            state     <= ST_HOLD;
          end else begin
            drain_cnt <= drain_cnt - 1'b1;
          end
        end
        ST_HOLD: begin
          if (res_ready) begin
            res_valid <= 1'b0;
            mac_clr   <= 1'b1;
            state     <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_dlfloat_mac_seq.sv
// Bench for dlfloat_mac_seq with a behavioural DLFloat16 MAC beside it and a
// scoreboard of expected dot-product results.
module tb_dlfloat_mac_seq;

  localparam int CNT_W = 8;

  typedef struct packed {
    logic [15:0]      data;
    logic [CNT_W-1:0] count;
    logic             nan;
  } exp_t;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic [15:0]      in_a = '0;
  logic [15:0]      in_b = '0;
  logic             in_last = 1'b0;
  logic             in_valid = 1'b0;
  logic             in_ready;
  logic [15:0]      mac_a, mac_b, mac_c;
  logic             mac_clr;
  logic [15:0]      res_data;
  logic [CNT_W-1:0] res_count;
  logic             res_nan;
  logic             res_valid;
  logic             res_ready = 1'b1;

  int   n_checks = 0;
  int   n_fails  = 0;
  int   cyc      = 0;
  int   acc_cyc  = 0;
  int   rise_cyc = 0;
  logic rv_q     = 1'b0;
  exp_t sb[$];
  exp_t mon_e;

  dlfloat_mac_seq #(.MAC_LAT(4), .ISSUE_GAP(2), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst),
    .in_a(in_a), .in_b(in_b), .in_last(in_last), .in_valid(in_valid), .in_ready(in_ready),
    .mac_a(mac_a), .mac_b(mac_b), .mac_clr(mac_clr), .mac_c(mac_c),
    .res_data(res_data), .res_count(res_count), .res_nan(res_nan),
    .res_valid(res_valid), .res_ready(res_ready)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fails++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // ---- behavioural MAC: two product stages then accumulate, cleared by mac_clr
  function automatic real dlf2r(input logic [15:0] x);
    real m;
    int  e;
    if (x[14:0] == 15'd0) return 0.0;
    e = int'(x[14:9]) - 31;
    m = 1.0 + real'(x[8:0]) / 512.0;
    while (e > 0) begin m = m * 2.0; e--; end
    while (e < 0) begin m = m / 2.0; e++; end
    return x[15] ? -m : m;
  endfunction

  function automatic logic [15:0] r2dlf(input real v);
    logic       s;
    int         e;
    real        m;
    logic [8:0] f;
    if (v == 0.0) return 16'h0000;
    s = (v < 0.0);
    m = s ? -v : v;
    e = 31;
    while (m >= 2.0) begin m = m / 2.0; e++; end
    while (m < 1.0)  begin m = m * 2.0; e--; end
    f = 9'($rtoi((m - 1.0) * 512.0));
    return {s, 6'(e), f};
  endfunction

  real  st1 = 0.0, st2 = 0.0, acc = 0.0;
  logic n1 = 1'b0, n2 = 1'b0, nacc = 1'b0;

  always @(posedge clk) begin
    if (mac_clr) begin
      st1 <= 0.0; st2 <= 0.0; acc <= 0.0;
      n1 <= 1'b0; n2 <= 1'b0; nacc <= 1'b0;
    end else begin
      st1  <= dlf2r(mac_a) * dlf2r(mac_b);
      n1   <= (mac_a == 16'hFFFF) || (mac_b == 16'hFFFF);
      st2  <= st1;
      n2   <= n1;
      acc  <= acc + st2;
      nacc <= nacc | n2;
    end
  end

  always_comb mac_c = nacc ? 16'hFFFF : r2dlf(acc);

  // ---- result monitor / scoreboard
  always @(negedge clk) begin
    if (!rst) begin
      if (res_valid && !rv_q) rise_cyc = cyc;
      rv_q = res_valid;
      if (res_valid && res_ready) begin
        if (sb.size() == 0) begin
          check("unexpected_result", 32'd1, 32'd0);
        end else begin
          mon_e = sb.pop_front();
          check("res_data", 32'(res_data), 32'(mon_e.data));
          check("res_count", 32'(res_count), 32'(mon_e.count));
          check("res_nan", 32'(res_nan), 32'(mon_e.nan));
        end
      end
    end else begin
      rv_q = 1'b0;
    end
  end

  // ---- stimulus helpers (called right after a posedge)
  task automatic send_pair(input logic [15:0] a, input logic [15:0] b, input logic last);
    int waited;
    in_a = a; in_b = b; in_last = last; in_valid = 1'b1;
    waited = 0;
    @(negedge clk);
    while (!in_ready && waited < 50) begin
      waited++;
      @(negedge clk);
    end
    if (!in_ready) check("accept_timeout", 32'd1, 32'd0);
    @(posedge clk);
    #1;
    acc_cyc  = cyc;
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic wait_done();
    int n;
    n = 0;
    do begin
      @(negedge clk);
      #1;
      n++;
    end while (!(sb.size() == 0 && !res_valid) && n < 60);
    if (n >= 60) check("result_timeout", 32'd1, 32'd0);
    @(posedge clk);
    #1;
  endtask

  function automatic exp_t mk(input logic [15:0] d, input int c, input logic nan);
    exp_t e;
    e.data = d; e.count = CNT_W'(c); e.nan = nan;
    return e;
  endfunction

  initial begin
    int a1, a2, seen, n;

    // reset values
    @(negedge clk);
    check("rst_in_ready", 32'(in_ready), 32'd0);
    check("rst_mac_clr", 32'(mac_clr), 32'd1);
    check("rst_mac_a", 32'(mac_a), 32'd0);
    check("rst_res_valid", 32'(res_valid), 32'd0);
    check("rst_res_data", 32'(res_data), 32'd0);
    check("rst_res_count", 32'(res_count), 32'd0);
    rst = 1'b0;
    @(posedge clk); #1;
    check("idle_in_ready", 32'(in_ready), 32'd1);

    // single-pair vector, latency
    sb.push_back(mk(16'h3E00, 1, 1'b0));
    send_pair(16'h3E00, 16'h3E00, 1'b1);
    check("clr_drop", 32'(mac_clr), 32'd0);
    check("issue_a", 32'(mac_a), 32'h3E00);
    wait_done();
    check("latency", 32'(rise_cyc - acc_cyc), 32'd4);

    // held valid: ready pattern 1,0,1 and accept spacing
    sb.push_back(mk(16'h4280, 2, 1'b0));
    in_a = 16'h3E00; in_b = 16'h4000; in_last = 1'b0; in_valid = 1'b1;
    @(negedge clk);
    check("rdy_p0", 32'(in_ready), 32'd1);
    @(posedge clk); #1;
    a1 = cyc;
    in_a = 16'h3F00; in_b = 16'h4000; in_last = 1'b1;
    @(negedge clk);
    check("rdy_p1", 32'(in_ready), 32'd0);
    @(posedge clk); #1;
    @(negedge clk);
    check("rdy_p2", 32'(in_ready), 32'd1);
    @(posedge clk); #1;
    a2 = cyc;
    in_valid = 1'b0; in_last = 1'b0;
    check("accept_gap", 32'(a2 - a1), 32'd2);
    check("drain_ready", 32'(in_ready), 32'd0);
    wait_done();

    // NaN vector then a clean one
    sb.push_back(mk(16'hFFFF, 1, 1'b1));
    send_pair(16'hFFFF, 16'h3E00, 1'b1);
    wait_done();
    sb.push_back(mk(16'h3E00, 1, 1'b0));
    send_pair(16'h3E00, 16'h3E00, 1'b1);
    wait_done();

    // back-pressure in HOLD
    res_ready = 1'b0;
    sb.push_back(mk(16'h3E00, 1, 1'b0));
    send_pair(16'h3E00, 16'h3E00, 1'b1);
    n = 0;
    while (!res_valid && n < 20) begin @(negedge clk); n++; end
    check("hold_reached", 32'(res_valid), 32'd1);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("hold_data", 32'(res_data), 32'h3E00);
      check("hold_ready", 32'(in_ready), 32'd0);
    end
    @(posedge clk); #1;
    res_ready = 1'b1;
    @(posedge clk); #1;
    check("idle_clr", 32'(mac_clr), 32'd1);
    check("idle_valid", 32'(res_valid), 32'd0);
    @(negedge clk);
    check("idle_clr_hold", 32'(mac_clr), 32'd1);
    @(posedge clk); #1;

    // 3-element vector, gapless then with 3-cycle gaps: 1 + 2 + 3 = 6.0
    sb.push_back(mk(16'h4300, 3, 1'b0));
    send_pair(16'h3E00, 16'h3E00, 1'b0);
    send_pair(16'h3E00, 16'h4000, 1'b0);
    send_pair(16'h3F00, 16'h4000, 1'b1);
    wait_done();
    sb.push_back(mk(16'h4300, 3, 1'b0));
    send_pair(16'h3E00, 16'h3E00, 1'b0);
    @(posedge clk);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("gap_zero_a", 32'(mac_a), 32'd0);
    end
    @(posedge clk); #1;
    send_pair(16'h3E00, 16'h4000, 1'b0);
    @(posedge clk);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("gap_zero_b", 32'(mac_b), 32'd0);
    end
    @(posedge clk); #1;
    send_pair(16'h3F00, 16'h4000, 1'b1);
    wait_done();

    // reset in the middle of WAIT
    send_pair(16'h3E00, 16'h3E00, 1'b0);
    check("in_wait", 32'(in_ready), 32'd0);
    #2 rst = 1'b1;
    #1;
    check("mrst_clr", 32'(mac_clr), 32'd1);
    check("mrst_mac_a", 32'(mac_a), 32'd0);
    check("mrst_valid", 32'(res_valid), 32'd0);
    check("mrst_count", 32'(res_count), 32'd0);
    check("mrst_data", 32'(res_data), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    seen = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (res_valid) seen++;
    end
    check("mrst_no_result", 32'(seen), 32'd0);
    check("mrst_idle_ready", 32'(in_ready), 32'd1);

    check("sb_empty", 32'(sb.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1);
  end

endmodule
